// File: rtl/updown_sched_pkg.sv
// Shared types and helpers for the up/down step scheduler.
// Holds the FSM encoding, direction codes and round-robin pick.
package updown_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MAXREQ = 32;

  // First set request at or after ptr, searching cyclically over n.
  function automatic logic [4:0] rr_pick(
    input logic [MAXREQ-1:0] req,
    input int                n,
    input int                ptr
  );
    int idx;
    rr_pick = '0;
    for (int k = MAXREQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) rr_pick = idx[4:0];
      end
    end
  endfunction

endpackage

// File: rtl/updown_step_counter.sv
// Wrapping up/down counter stepped by a one-cycle enable.
// Direction is sampled on the same edge as the enable.
module updown_step_counter
  import updown_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  // Step by one in the requested direction, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (up == DIR_UP) count <= count + WIDTH'(1);
      else              count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_step_scheduler.sv
// Round-robin arbiter plus sequencer sharing one step counter.
// One command runs at a time; done pulses once per command.
module updown_step_scheduler
  import updown_sched_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int NREQ     = 2,
  parameter int STEPW    = 4,
  parameter int PRESCALE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_dir,
  input  logic [NREQ*STEPW-1:0]    req_steps,
  input  logic                     abort,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     done_aborted,
  output logic [WIDTH-1:0]         count
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  state_t            state, state_n;
  logic [IDW-1:0]    ptr, id_r, sel;
  logic              dir_r, aborted_r;
  logic [STEPW-1:0]  rem, sel_steps;
  logic [PCW-1:0]    pc;
  logic [NREQ-1:0]   gnt_r;
  logic [MAXREQ-1:0] req_x;
  logic              accept, step, abort_hit, pc_wrap;

  // Round-robin selection of the next command.
  always_comb begin
    req_x            = '0;
    req_x[NREQ-1:0]  = req;
    sel              = IDW'(rr_pick(req_x, NREQ, int'(ptr)));
    sel_steps        = req_steps[int'(sel)*STEPW +: STEPW];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    step      = 1'b0;
    abort_hit = 1'b0;
    pc_wrap   = (pc == PC_LAST);
    unique case (state)
      IDLE: begin
        if (|req) begin
          accept  = 1'b1;
          state_n = (sel_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_n   = DONE;
        end else if (pc_wrap) begin
          step = 1'b1;
          if (rem == STEPW'(1)) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command latch, prescaler, step budget and grant pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      id_r      <= '0;
      dir_r     <= DIR_DOWN;
      rem       <= '0;
      pc        <= '0;
      gnt_r     <= '0;
      aborted_r <= 1'b0;
    end else begin
      gnt_r <= '0;
      if (accept) begin
        gnt_r     <= NREQ'(1) << sel;
        id_r      <= sel;
        dir_r     <= req_dir[sel];
        rem       <= sel_steps;
        pc        <= '0;
        aborted_r <= 1'b0;
        ptr       <= (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
      end
      if (state == RUN) begin
        if (abort_hit) begin
          aborted_r <= 1'b1;
          pc        <= '0;
        end else if (step) begin
          rem <= rem - STEPW'(1);
          pc  <= '0;
        end else begin
          pc <= pc + PCW'(1);
        end
      end
    end
  end

  updown_step_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (step),
    .up    (dir_r),
    .count (count)
  );

  assign gnt          = gnt_r;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign done_id      = id_r;
  assign done_aborted = done & aborted_r;

endmodule

// File: tb/tb_updown_step_scheduler.sv
// Self-checking bench for updown_step_scheduler.
// Uses a position/grant model built from the command rules.
module tb_updown_step_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, abort;
  logic [1:0] req, req_dir, gnt;
  logic [7:0] req_steps;
  logic       busy, done, done_id, done_aborted;
  logic [3:0] count;

  logic       p_reset, p_abort;
  logic [1:0] p_req, p_req_dir, p_gnt;
  logic [7:0] p_req_steps;
  logic       p_busy, p_done, p_done_id, p_done_aborted;
  logic [3:0] p_count;

  int total = 0;
  int bad   = 0;
  int m_count;
  int m_ptr;

  updown_step_scheduler #(
    .WIDTH(4), .NREQ(2), .STEPW(4), .PRESCALE(1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_dir(req_dir),
    .req_steps(req_steps), .abort(abort), .gnt(gnt),
    .busy(busy), .done(done), .done_id(done_id),
    .done_aborted(done_aborted), .count(count)
  );

  updown_step_scheduler #(
    .WIDTH(4), .NREQ(2), .STEPW(4), .PRESCALE(3)
  ) dut3 (
    .clk(clk), .reset(p_reset), .req(p_req), .req_dir(p_req_dir),
    .req_steps(p_req_steps), .abort(p_abort), .gnt(p_gnt),
    .busy(p_busy), .done(p_done), .done_id(p_done_id),
    .done_aborted(p_done_aborted), .count(p_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [1:0] m, input int p);
    for (int k = 0; k < 2; k++)
      if (m[(p + k) % 2]) return (p + k) % 2;
    return -1;
  endfunction

  function automatic int mv(input int c, input logic up, input int n);
    return up ? (c + n) % 16 : (c + 16 * 16 - n) % 16;
  endfunction

  task automatic do_reset;
    reset = 1'b1; req = '0; abort = 1'b0;
    req_dir = '0; req_steps = '0;
    tick; tick;
    reset = 1'b0;
    m_count = 0; m_ptr = 0;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (count !== 4'd0) begin bad++;
      $display("FAIL rst_count got %0d want 0", count); end
    total++; if (gnt !== 2'b00) begin bad++;
      $display("FAIL rst_gnt got %b want 00", gnt); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++;
      $display("FAIL rst_done got %b want 0", done); end
    total++; if (done_id !== 1'b0) begin bad++;
      $display("FAIL rst_done_id got %b want 0", done_id); end
    total++; if (done_aborted !== 1'b0) begin bad++;
      $display("FAIL rst_aborted got %b want 0", done_aborted); end
  endtask

  task automatic test_up;
    do_reset;
    req_dir = 2'b01; req_steps = {4'd0, 4'd3}; req = 2'b01;
    tick;
    total++; if (gnt !== 2'b01) begin bad++;
      $display("FAIL up_gnt got %b want 01", gnt); end
    req = '0;
    for (int i = 1; i <= 3; i++) begin
      total++; if (done !== 1'b0) begin bad++;
        $display("FAIL up_early_done step %0d got %b want 0", i, done); end
      tick;
      m_count = mv(m_count, 1'b1, 1);
      total++; if (count !== 4'(m_count)) begin bad++;
        $display("FAIL up_count step %0d got %0d want %0d",
                 i, count, m_count); end
    end
    total++; if (done !== 1'b1 || done_id !== 1'b0
                 || done_aborted !== 1'b0) begin bad++;
      $display("FAIL up_done got %b/%b/%b want 1/0/0",
               done, done_id, done_aborted); end
    tick;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL up_idle got busy=%b done=%b want 0/0",
               busy, done); end
  endtask

  task automatic test_down;
    do_reset;
    req_dir = 2'b00; req_steps = {4'd2, 4'd0}; req = 2'b10;
    tick;
    total++; if (gnt !== 2'b10) begin bad++;
      $display("FAIL down_gnt got %b want 10", gnt); end
    req = '0;
    for (int i = 1; i <= 2; i++) begin
      tick;
      m_count = mv(m_count, 1'b0, 1);
      total++; if (count !== 4'(m_count)) begin bad++;
        $display("FAIL down_count step %0d got %0d want %0d",
                 i, count, m_count); end
    end
    total++; if (done !== 1'b1 || done_id !== 1'b1) begin bad++;
      $display("FAIL down_done got %b/%b want 1/1", done, done_id); end
    tick;
  endtask

  task automatic test_rr;
    int exp_id, w;
    do_reset;
    req_dir = 2'b11; req_steps = {4'd1, 4'd1}; req = 2'b11;
    for (int c = 0; c < 4; c++) begin
      exp_id = pick(req, m_ptr);
      m_ptr = (exp_id + 1) % 2;
      w = 0;
      do begin tick; w++; end while (gnt == 2'b00 && w < 8);
      total++; if (gnt !== 2'(1 << exp_id)) begin bad++;
        $display("FAIL rr_gnt cmd %0d got %b want %0d-hot",
                 c, gnt, exp_id); end
      tick;
      m_count = mv(m_count, 1'b1, 1);
      total++; if (done !== 1'b1 || done_id !== 1'(exp_id)
                   || count !== 4'(m_count)) begin bad++;
        $display("FAIL rr_done cmd %0d got %b/%b/%0d want 1/%0d/%0d",
                 c, done, done_id, count, exp_id, m_count); end
    end
    req = '0;
    tick; tick;
  endtask

  task automatic test_zero;
    do_reset;
    req_dir = 2'b01; req_steps = 8'h00; req = 2'b01;
    tick;
    total++; if (gnt !== 2'b01 || done !== 1'b1 || busy !== 1'b1
                 || done_id !== 1'b0 || count !== 4'd0) begin bad++;
      $display("FAIL zero_done got g=%b d=%b b=%b id=%b c=%0d",
               gnt, done, busy, done_id, count); end
    req = '0;
    tick;
    total++; if (busy !== 1'b0 || done !== 1'b0
                 || count !== 4'd0) begin bad++;
      $display("FAIL zero_after got b=%b d=%b c=%0d want 0/0/0",
               busy, done, count); end
  endtask

  task automatic test_prescale;
    p_reset = 1'b1; tick; tick; p_reset = 1'b0;
    p_req_dir = 2'b01; p_req_steps = {4'd0, 4'd2}; p_req = 2'b01;
    tick;
    total++; if (p_gnt !== 2'b01) begin bad++;
      $display("FAIL ps_gnt got %b want 01", p_gnt); end
    p_req = '0;
    for (int t = 1; t <= 6; t++) begin
      tick;
      total++; if (p_count !== 4'(t / 3)
                   || p_done !== (t == 6)) begin bad++;
        $display("FAIL ps_edge %0d got c=%0d d=%b want c=%0d d=%b",
                 t, p_count, p_done, t / 3, (t == 6)); end
    end
    tick;
    total++; if (p_busy !== 1'b0) begin bad++;
      $display("FAIL ps_idle got busy=%b want 0", p_busy); end
  endtask

  task automatic test_abort;
    do_reset;
    req_dir = 2'b01; req_steps = {4'd0, 4'd10}; req = 2'b01;
    tick; req = '0;
    tick; tick; tick;
    total++; if (count !== 4'd3) begin bad++;
      $display("FAIL ab_pre got %0d want 3", count); end
    abort = 1'b1; tick; abort = 1'b0;
    total++; if (done !== 1'b1 || done_aborted !== 1'b1
                 || done_id !== 1'b0 || count !== 4'd3) begin bad++;
      $display("FAIL ab_done got d=%b a=%b id=%b c=%0d want 1/1/0/3",
               done, done_aborted, done_id, count); end
    tick;
    total++; if (busy !== 1'b0 || count !== 4'd3) begin bad++;
      $display("FAIL ab_idle got b=%b c=%0d want 0/3", busy, count); end
  endtask

  task automatic test_reset_mid;
    int seen;
    do_reset;
    req_dir = 2'b01; req_steps = {4'd0, 4'd10}; req = 2'b01;
    tick; req = '0;
    tick; tick; tick;
    reset = 1'b1; tick; reset = 1'b0;
    total++; if (count !== 4'd0 || busy !== 1'b0
                 || done !== 1'b0) begin bad++;
      $display("FAIL rm_state got c=%0d b=%b d=%b want 0/0/0",
               count, busy, done); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (done === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++;
      $display("FAIL rm_nodone got %0d pulses want 0", seen); end
    req_dir = 2'b00; req_steps = {4'd1, 4'd1}; req = 2'b11;
    tick;
    total++; if (gnt !== 2'b01) begin bad++;
      $display("FAIL rm_gnt got %b want 01", gnt); end
    req = '0;
    tick; tick;
  endtask

  task automatic test_random;
    int st[2];
    logic [1:0] m, d;
    int id, n, cut;
    logic ab;
    do_reset;
    for (int it = 0; it < 30; it++) begin
      m = 2'($urandom_range(1, 3));
      d = 2'($urandom_range(0, 3));
      st[0] = $urandom_range(0, 6);
      st[1] = $urandom_range(0, 6);
      id = pick(m, m_ptr);
      m_ptr = (id + 1) % 2;
      n = st[id];
      ab = (n > 1) && ($urandom_range(0, 2) == 0);
      cut = ab ? $urandom_range(1, n - 1) : n;
      req_dir = d; req = m;
      req_steps = {4'(st[1]), 4'(st[0])};
      tick;
      total++; if (gnt !== 2'(1 << id)) begin bad++;
        $display("FAIL rnd_gnt it %0d got %b want %0d-hot",
                 it, gnt, id); end
      req = '0;
      for (int i = 0; i < cut; i++) tick;
      if (ab) begin
        abort = 1'b1; tick; abort = 1'b0;
      end
      m_count = mv(m_count, d[id], cut);
      total++; if (done !== 1'b1 || done_id !== 1'(id)
                   || done_aborted !== ab
                   || count !== 4'(m_count)) begin bad++;
        $display("FAIL rnd_done it %0d got %b/%b/%b/%0d want 1/%0d/%b/%0d",
                 it, done, done_id, done_aborted, count,
                 id, ab, m_count); end
      tick;
      total++; if (busy !== 1'b0) begin bad++;
        $display("FAIL rnd_idle it %0d got busy=%b want 0", it, busy); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    p_reset = 1'b1; p_req = '0; p_req_dir = '0;
    p_req_steps = '0; p_abort = 1'b0;
    test_reset;
    test_up;
    test_down;
    test_rr;
    test_zero;
    test_prescale;
    test_abort;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_step_scheduler.md
Name: updown_step_scheduler

Overview:
Shares one wrapping up/down step counter between NREQ requesters. Each requester issues a move command: a direction plus a step count. A round-robin arbiter accepts one command at a time, and a sequencer FSM steps the counter once every PRESCALE cycles until the command completes or is aborted. Completion is reported with a one-cycle done pulse tagged with the requester index. The block sits between motion/position clients and the shared position count.

Parameters:
WIDTH, 4, counter width; count wraps modulo 2^WIDTH
NREQ, 2, number of requesters (>=2)
STEPW, 4, width of each step-count field
PRESCALE, 1, clock cycles per counter step (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset
req  in  NREQ  per-requester command request; held until matching gnt
req_dir  in  NREQ  per-requester direction: 1 = up, 0 = down
req_steps  in  NREQ*STEPW  per-requester step count; field i = bits [i*STEPW +: STEPW]
abort  in  1  terminate the active command
gnt  out  NREQ  one-hot, one-cycle command-accepted pulse
busy  out  1  command in progress (state RUN or DONE)
done  out  1  one-cycle completion pulse
done_id  out  $clog2(NREQ)  index of the completed requester; valid with done
done_aborted  out  1  completion was caused by abort; valid with done
count  out  WIDTH  current counter value

Behaviour:
- Reset is synchronous, active-high, clock clk. It has priority over all other inputs.
- Reset values: count=0, gnt=0, busy=0, done=0, done_id=0, done_aborted=0, state=IDLE, RR pointer=0, prescale counter=0, remaining=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is set, select the first set bit at or after the RR pointer (cyclic search).
  - At that clock edge: latch dir and steps of the selected requester, record its id, set RR pointer = (id+1) mod NREQ.
  - Next state is RUN, or DONE if steps==0.
  - Exactly one gnt bit is high in the first cycle after the accepting edge.
  - If no req bit is set, stay in IDLE.
- RUN:
  - The prescale counter increments each cycle.
  - When it reaches PRESCALE-1: step count (up: +1, 15->0 wrap; down: -1, 0->15 wrap for WIDTH=4), decrement remaining, clear the prescale counter.
  - The edge performing the last step (remaining==1) moves the FSM to DONE.
  - First step occurs PRESCALE edges after acceptance.
- DONE: done=1 for exactly one cycle with done_id; next state is IDLE.
- Timing: accept-to-done pulse is N*PRESCALE cycles for N>0, and 1 cycle for N==0. A new acceptance happens no earlier than the edge after the done cycle, so at least one IDLE cycle separates commands.
- abort:
  - Sampled only in RUN. On abort: no step at that edge (abort wins over a coincident step), next state DONE, done_aborted=1.
  - Ignored in IDLE and DONE.
- Requester protocol:
  - req_dir/req_steps must be stable while req is high and before gnt.
  - A req still high after gnt is treated as a new command at the next IDLE.
  - Dropping req before gnt withdraws the request with no side effect.
- Interface stability: req inputs are ignored in RUN and DONE. count changes only on steps and reset.
- Reset mid-operation: the command is discarded silently (no done), count returns to 0, RR pointer returns to 0.

Decomposition:
- Package updown_sched_pkg:
  - state enum {IDLE, RUN, DONE}
  - DIR_UP=1, DIR_DOWN=0
  - helper function for the round-robin pick
- One sub-module, updown_step_counter:
  - WIDTH-bit wrapping counter with enable and direction
  - synchronous active-high reset to 0
  - instantiated once
- Arbiter and FSM live in the top module.

Test Plan (WIDTH=4, NREQ=2, STEPW=4, PRESCALE=1 unless noted):
1. After reset, req0 up, steps=3 -> gnt=01 for one cycle; count 1,2,3 on consecutive edges; done with done_id=0, done_aborted=0; final count=3.
2. From count=0, req1 down, steps=2 -> gnt=10; count 15 then 14; done_id=1.
3. req0 and req1 held high continuously, steps=1 each -> grant order 0,1,0,1; each done carries the matching id.
4. req0 steps=0 -> gnt then done on the following cycle; count unchanged; busy high for exactly 1 cycle.
5. PRESCALE=3, req0 up, steps=2 -> count steps 3 and 6 edges after acceptance; done 6 cycles after acceptance.
6. Abort and reset mid-run:
   - req0 up, steps=10, abort asserted after 3 steps -> count=3, done with done_aborted=1.
   - Repeat with reset instead of abort -> count=0, busy=0, no done, next grant goes to req0.
